// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count step scheduler: FSM state
// encoding, step direction values and the drop-counter width.
package count_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_UP,
    PRESS_DN,
    REPEAT_UP,
    REPEAT_DN,
    LOCKOUT
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned DROP_W = 8;

  // Bits needed to count 0 .. max(a, b)-1; never narrower than one bit.
  function automatic int unsigned timer_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/count_step_scheduler_if.sv
// Button levels and step handshake between the debouncers, the scheduler and
// the counter. o_Drop_Count exists only when STEP_DROP_COUNT_EN is defined.
interface count_step_scheduler_if;
  import count_ctrl_pkg::*;

  logic i_Up;
  logic i_Down;
  logic i_Step_Ready;
  logic o_Step_Valid;
  logic o_Step_Dir;
  logic o_Repeat_Active;
`ifdef STEP_DROP_COUNT_EN
  logic [DROP_W-1:0] o_Drop_Count;
`endif

  // Scheduler side.
  modport slave (
    input  i_Up, i_Down, i_Step_Ready,
    output o_Step_Valid, o_Step_Dir, o_Repeat_Active
`ifdef STEP_DROP_COUNT_EN
    , output o_Drop_Count
`endif
  );

  // Stimulus / consumer side.
  modport master (
    output i_Up, i_Down, i_Step_Ready,
    input  o_Step_Valid, o_Step_Dir, o_Repeat_Active
`ifdef STEP_DROP_COUNT_EN
    , input o_Drop_Count
`endif
  );

endinterface

// File: rtl/step_timer.sv
// Shared hold/repeat timer: counts while enabled, wraps to zero on reaching
// the runtime limit, and is held at zero while cleared.
module step_timer #(
  parameter int unsigned W = 4
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  // done does not depend on enable, so the FSM can gate it without a comb loop.
  assign done = (count == limit);

  always_ff @(posedge i_Clk) begin
    if (i_Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (done) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/count_step_scheduler.sv
// Turns debounced up/down button levels into single step commands with
// hold-to-repeat and conflict lockout. Optional: STEP_DROP_COUNT_EN.
module count_step_scheduler
  import count_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 12500000,
  parameter int unsigned REPEAT_CYCLES = 2500000
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  count_step_scheduler_if.slave bus
);

  localparam int unsigned       TIMER_W    = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [TIMER_W-1:0] HOLD_LIM   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LIM = TIMER_W'(REPEAT_CYCLES - 1);

  state_t state, next_state;

  logic up_prev, down_prev;
  logic up_edge, down_edge;

  logic step_valid, step_dir, repeat_active;
  logic valid_d, dir_d, repeat_d;

  logic issue, issue_dir;
  logic retire, load;

  logic               tmr_en, tmr_done;
  logic [TIMER_W-1:0] tmr_limit;

  assign up_edge   = bus.i_Up   & ~up_prev;
  assign down_edge = bus.i_Down & ~down_prev;

  assign tmr_limit = (state == REPEAT_UP || state == REPEAT_DN) ? REPEAT_LIM : HOLD_LIM;

  step_timer #(.W(TIMER_W)) u_timer (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .clear   (!tmr_en),
    .enable  (tmr_en),
    .limit   (tmr_limit),
    .done    (tmr_done)
  );

  // Edge history resets high so a button held through reset stays silent.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= IDLE;
      up_prev       <= 1'b1;
      down_prev     <= 1'b1;
      step_valid    <= 1'b0;
      step_dir      <= DIR_DOWN;
      repeat_active <= 1'b0;
    end else begin
      state         <= next_state;
      up_prev       <= bus.i_Up;
      down_prev     <= bus.i_Down;
      step_valid    <= valid_d;
      step_dir      <= dir_d;
      repeat_active <= repeat_d;
    end
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    issue_dir  = DIR_DOWN;
    tmr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (up_edge && down_edge) begin
          next_state = LOCKOUT;
        end else if (up_edge) begin
          if (bus.i_Down) begin
            next_state = LOCKOUT;
          end else begin
            issue      = 1'b1;
            issue_dir  = DIR_UP;
            next_state = PRESS_UP;
          end
        end else if (down_edge) begin
          if (bus.i_Up) begin
            next_state = LOCKOUT;
          end else begin
            issue      = 1'b1;
            issue_dir  = DIR_DOWN;
            next_state = PRESS_DN;
          end
        end
      end
      PRESS_UP, REPEAT_UP: begin
        if (!bus.i_Up) begin
          next_state = IDLE;
        end else if (bus.i_Down) begin
          next_state = LOCKOUT;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            issue      = 1'b1;
            issue_dir  = DIR_UP;
            next_state = REPEAT_UP;
          end
        end
      end
      PRESS_DN, REPEAT_DN: begin
        if (!bus.i_Down) begin
          next_state = IDLE;
        end else if (bus.i_Up) begin
          next_state = LOCKOUT;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            issue      = 1'b1;
            issue_dir  = DIR_DOWN;
            next_state = REPEAT_DN;
          end
        end
      end
      LOCKOUT: begin
        if (!bus.i_Up && !bus.i_Down) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A new step may take the output slot only if it is empty or being
  // accepted this same cycle; otherwise the pending step wins.
  always_comb begin
    retire   = step_valid & bus.i_Step_Ready;
    load     = issue & (~step_valid | retire);
    valid_d  = step_valid;
    dir_d    = step_dir;
    if (load) begin
      valid_d = 1'b1;
      dir_d   = issue_dir;
    end else if (retire) begin
      valid_d = 1'b0;
    end
    repeat_d = (next_state == REPEAT_UP) || (next_state == REPEAT_DN);
  end

  assign bus.o_Step_Valid    = step_valid;
  assign bus.o_Step_Dir      = step_dir;
  assign bus.o_Repeat_Active = repeat_active;

`ifdef STEP_DROP_COUNT_EN
  logic              both_lock;
  logic [DROP_W-1:0] drop_count;

  assign both_lock = (state == IDLE) && up_edge && down_edge;

  always_ff @(posedge i_Clk) begin
    if (i_Reset || both_lock) begin
      drop_count <= '0;
    end else if (issue && !load && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign bus.o_Drop_Count = drop_count;
`endif

endmodule

// File: tb/tb_count_step_scheduler.sv
// Self-checking bench for count_step_scheduler (HOLD_CYCLES=8, REPEAT_CYCLES=3):
// per-cycle vector table plus a scoreboard of accepted step directions.
module tb_count_step_scheduler;
  import count_ctrl_pkg::*;

  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 3;

  logic clk = 1'b0;
  logic rst;

  count_step_scheduler_if bus();

  count_step_scheduler #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // One row = inputs held for one clock edge and the outputs expected after it.
  typedef struct {
    logic        rst, up, dn, rdy;
    logic        v, d, r;
    int unsigned drop;
    bit          push;
  } vec_t;

  vec_t tbl[$];
  logic sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(int unsigned n, logic rst_i, logic up_i, logic dn_i, logic rdy_i,
                     logic v_i, logic d_i, logic r_i, int unsigned drop_i, bit push_i);
    vec_t e;
    e.rst = rst_i; e.up = up_i; e.dn = dn_i; e.rdy = rdy_i;
    e.v = v_i; e.d = d_i; e.r = r_i; e.drop = drop_i;
    for (int unsigned k = 0; k < n; k++) begin
      e.push = push_i && (k == 0);
      tbl.push_back(e);
    end
  endtask

  task automatic chk(string name, int row, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, exp);
    end
  endtask

  initial begin
    logic exp_dir;

    // A: up held through reset, then released and pressed again
    add(2,  1, 1, 0, 1,  0, 0, 0, 0, 0);
    add(20, 0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1,  0, 1, 0, 1,  1, 1, 0, 0, 1);
    add(2,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    // B: 4-cycle up pulse -> one step, no repeat
    add(1,  0, 1, 0, 1,  1, 1, 0, 0, 1);
    add(3,  0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(2,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    // C: down held 17 cycles -> steps at rows 1, 9, 12, 15
    add(1,  0, 0, 1, 1,  1, 0, 0, 0, 1);
    add(7,  0, 0, 1, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 1, 1,  1, 0, 1, 0, 1);
    add(2,  0, 0, 1, 1,  0, 0, 1, 0, 0);
    add(1,  0, 0, 1, 1,  1, 0, 1, 0, 1);
    add(2,  0, 0, 1, 1,  0, 0, 1, 0, 0);
    add(1,  0, 0, 1, 1,  1, 0, 1, 0, 1);
    add(2,  0, 0, 1, 1,  0, 0, 1, 0, 0);
    add(4,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    // D: simultaneous press -> lockout; re-press up while down high; exit
    add(5,  0, 1, 1, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 1, 1,  0, 0, 0, 0, 0);
    add(2,  0, 1, 1, 1,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1,  0, 1, 0, 1,  1, 1, 0, 0, 1);
    add(1,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    // E: up auto-repeat with consumer stalled; two repeats dropped
    add(1,  0, 1, 0, 1,  1, 1, 0, 0, 1);
    add(1,  0, 1, 0, 1,  0, 0, 0, 0, 0);
    add(6,  0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(1,  0, 1, 0, 0,  1, 1, 1, 0, 1);
    add(2,  0, 1, 0, 0,  1, 1, 1, 0, 0);
    add(3,  0, 1, 0, 0,  1, 1, 1, 1, 0);
    add(1,  0, 1, 0, 0,  1, 1, 1, 2, 0);
    add(1,  0, 1, 0, 1,  0, 0, 1, 2, 0);
    add(1,  0, 1, 0, 0,  0, 0, 1, 2, 0);
    add(1,  0, 1, 0, 0,  1, 1, 1, 2, 0);  // never accepted: reset drops it
    // F: reset while a step is pending in REPEAT_UP
    add(1,  1, 1, 0, 0,  0, 0, 0, 0, 0);
    add(1,  0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(1,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1,  0, 1, 0, 1,  1, 1, 0, 0, 1);
    add(1,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    // G: back-to-back accept and issue; direction swaps with valid held
    add(1,  0, 1, 0, 0,  1, 1, 0, 0, 1);
    add(1,  0, 0, 0, 0,  1, 1, 0, 0, 0);
    add(1,  0, 0, 1, 1,  1, 0, 0, 0, 1);
    add(2,  0, 0, 0, 1,  0, 0, 0, 0, 0);
    // H: a dropped down press, then a simultaneous press clears the drop count
    add(1,  0, 1, 0, 0,  1, 1, 0, 0, 1);
    add(1,  0, 0, 0, 0,  1, 1, 0, 0, 0);
    add(1,  0, 0, 1, 0,  1, 1, 0, 1, 0);
    add(1,  0, 0, 0, 0,  1, 1, 0, 1, 0);
    add(1,  0, 1, 1, 1,  0, 0, 0, 0, 0);
    add(2,  0, 0, 0, 1,  0, 0, 0, 0, 0);

    rst = 1'b1;
    bus.i_Up = 1'b0;
    bus.i_Down = 1'b0;
    bus.i_Step_Ready = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst              = tbl[i].rst;
      bus.i_Up         = tbl[i].up;
      bus.i_Down       = tbl[i].dn;
      bus.i_Step_Ready = tbl[i].rdy;

      // Handshake completing at the coming edge: pop the oldest expected step.
      @(negedge clk);
      if (!tbl[i].rst && bus.o_Step_Valid && bus.i_Step_Ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_accept", i, 1, 0);
        end else begin
          exp_dir = sb.pop_front();
          chk("sb_accept_dir", i, int'(bus.o_Step_Dir), int'(exp_dir));
        end
      end

      @(posedge clk);
      #1;
      chk("step_valid", i, int'(bus.o_Step_Valid), int'(tbl[i].v));
      if (tbl[i].v) chk("step_dir", i, int'(bus.o_Step_Dir), int'(tbl[i].d));
      chk("repeat_active", i, int'(bus.o_Repeat_Active), int'(tbl[i].r));
`ifdef STEP_DROP_COUNT_EN
      chk("drop_count", i, int'(bus.o_Drop_Count), int'(tbl[i].drop));
`endif
      if (tbl[i].push) sb.push_back(tbl[i].d);
    end

    chk("sb_leftover", tbl.size(), sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
